// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg : shared encodings for the fetch/data memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  function automatic logic [1:0] byte_enables(input logic is_byte, input logic a0);
    if (!is_byte) return BE_WORD;
    return a0 ? BE_HI : BE_LO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter_rr_arb2 : two-input round-robin picker (bit0=fetch, bit1=data)
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_bus_arbiter_rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_last == GNT_DATA) ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter : shares one 16-bit memory port between fetch and data
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic        m_valid,
  output logic        m_we,
  output logic [1:0]  m_be,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] c_timeout = 16'(TIMEOUT);

  state_t      r_state, w_state;
  logic        r_last, w_last;
  logic        r_gnt, w_gnt_id;
  logic        r_lane, w_lane;
  logic        r_byte, w_byte;
  logic [15:0] r_cnt, w_cnt;
  logic        r_m_valid, w_m_valid;
  logic        r_m_we, w_m_we;
  logic [1:0]  r_m_be, w_m_be;
  logic [15:0] r_m_addr, w_m_addr;
  logic [15:0] r_m_wdata, w_m_wdata;
  logic        r_f_ack, w_f_ack, r_f_err, w_f_err;
  logic        r_d_ack, w_d_ack, r_d_err, w_d_err;
  logic [15:0] r_f_rdata, w_f_rdata, r_d_rdata, w_d_rdata;

  logic [1:0]  w_gnt;
  logic        w_sel;
  logic [15:0] w_g_addr, w_g_wdata, w_rd_fmt, w_cnt_inc;
  logic        w_g_byte, w_g_we, w_misaligned;

  mem_bus_arbiter_rr_arb2 u_rr_arb2 (
    .i_req  ({d_req, f_req}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_sel        = w_gnt[1];
  assign w_g_addr     = w_sel ? d_addr : f_addr;
  assign w_g_byte     = w_sel & d_byte;
  assign w_g_we       = w_sel & d_we;
  assign w_g_wdata    = w_g_byte ? {d_wdata[7:0], d_wdata[7:0]} : (w_sel ? d_wdata : 16'h0000);
  assign w_misaligned = !w_g_byte && w_g_addr[0];
  assign w_cnt_inc    = r_cnt + 16'd1;
  // Byte reads pick the lane selected by address bit 0 and zero-extend it.
  assign w_rd_fmt     = !r_byte ? m_rdata : {8'h00, (r_lane ? m_rdata[15:8] : m_rdata[7:0])};

  always_comb begin
    w_state   = r_state;
    w_last    = r_last;
    w_gnt_id  = r_gnt;
    w_lane    = r_lane;
    w_byte    = r_byte;
    w_cnt     = r_cnt;
    w_m_valid = r_m_valid;
    w_m_we    = r_m_we;
    w_m_be    = r_m_be;
    w_m_addr  = r_m_addr;
    w_m_wdata = r_m_wdata;
    w_f_ack   = 1'b0;
    w_f_err   = 1'b0;
    w_f_rdata = 16'h0000;
    w_d_ack   = 1'b0;
    w_d_err   = 1'b0;
    w_d_rdata = 16'h0000;

    case (r_state)
      ST_IDLE: begin
        if (|w_gnt) begin
          w_last   = w_sel;
          w_gnt_id = w_sel;
          w_lane   = w_g_addr[0];
          w_byte   = w_g_byte;
          w_cnt    = 16'h0000;
          if (w_misaligned) begin
            w_state = ST_DONE;
            w_f_ack = !w_sel;
            w_f_err = !w_sel;
            w_d_ack = w_sel;
            w_d_err = w_sel;
          end else begin
            w_state   = w_sel ? ST_DATA : ST_FETCH;
            w_m_valid = 1'b1;
            w_m_we    = w_g_we;
            w_m_be    = byte_enables(w_g_byte, w_g_addr[0]);
            w_m_addr  = {w_g_addr[15:1], 1'b0};
            w_m_wdata = w_g_wdata;
          end
        end
      end
      ST_FETCH, ST_DATA: begin
        if (m_ready || (TIMEOUT != 0 && w_cnt_inc == c_timeout)) begin
          w_state   = ST_DONE;
          w_m_valid = 1'b0;
          w_m_we    = 1'b0;
          w_m_be    = 2'b00;
          w_m_addr  = 16'h0000;
          w_m_wdata = 16'h0000;
          w_f_ack   = (r_gnt == GNT_FETCH);
          w_d_ack   = (r_gnt == GNT_DATA);
          if (m_ready) begin
            w_f_rdata = (r_gnt == GNT_FETCH) ? w_rd_fmt : 16'h0000;
            w_d_rdata = (r_gnt == GNT_DATA) ? w_rd_fmt : 16'h0000;
          end else begin
            w_f_err = (r_gnt == GNT_FETCH);
            w_d_err = (r_gnt == GNT_DATA);
          end
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= GNT_FETCH;
      r_gnt     <= GNT_FETCH;
      r_lane    <= 1'b0;
      r_byte    <= 1'b0;
      r_cnt     <= 16'h0000;
      r_m_valid <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_be    <= 2'b00;
      r_m_addr  <= 16'h0000;
      r_m_wdata <= 16'h0000;
      r_f_ack   <= 1'b0;
      r_f_err   <= 1'b0;
      r_f_rdata <= 16'h0000;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= 16'h0000;
    end else begin
      r_state   <= w_state;
      r_last    <= w_last;
      r_gnt     <= w_gnt_id;
      r_lane    <= w_lane;
      r_byte    <= w_byte;
      r_cnt     <= w_cnt;
      r_m_valid <= w_m_valid;
      r_m_we    <= w_m_we;
      r_m_be    <= w_m_be;
      r_m_addr  <= w_m_addr;
      r_m_wdata <= w_m_wdata;
      r_f_ack   <= w_f_ack;
      r_f_err   <= w_f_err;
      r_f_rdata <= w_f_rdata;
      r_d_ack   <= w_d_ack;
      r_d_err   <= w_d_err;
      r_d_rdata <= w_d_rdata;
    end
  end

  assign f_ack     = r_f_ack;
  assign f_err     = r_f_err;
  assign f_rdata   = r_f_rdata;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;
  assign m_valid   = r_m_valid;
  assign m_we      = r_m_we;
  assign m_be      = r_m_be;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter : transaction-level model + per-cycle compare for the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_ack, f_err;
  logic [15:0] f_addr, f_rdata;
  logic        d_req, d_we, d_byte, d_ack, d_err;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        m_valid, m_we, m_ready;
  logic [1:0]  m_be;
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_valid(m_valid), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mv;
    logic        we;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        fack;
    logic        ferr;
    logic [15:0] frd;
    logic        dack;
    logic        derr;
    logic [15:0] drd;
    logic        chk_rd;
    logic        busy;
    logic [1:0]  st;
  } rec_t;

  rec_t q[$];
  rec_t cr;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   t0 = 0;

  // Pending requests held by the bench, plus the model's round-robin memory.
  logic        pf, pd, mdl_last;
  logic [15:0] pf_addr, pd_addr, pd_wdata;
  logic        pd_we, pd_byte;

  // Observations of the DUT, written only by the compare process.
  int          cap_mv_first = -1, cap_mv_run = 0, cap_ack_cyc = -1;
  logic        cap_ack_d, cap_mwe, cap_ferr, cap_derr, prev_mv = 1'b0;
  logic [15:0] cap_frd, cap_drd, cap_maddr, cap_mwdata;
  logic [1:0]  cap_mbe;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cr = q.pop_front();
      chk("state", {14'd0, dbg_state}, {14'd0, cr.st});
      chk("busy", {15'd0, busy}, {15'd0, cr.busy});
      chk("m_valid", {15'd0, m_valid}, {15'd0, cr.mv});
      chk("f_ack", {15'd0, f_ack}, {15'd0, cr.fack});
      chk("d_ack", {15'd0, d_ack}, {15'd0, cr.dack});
      if (cr.mv) begin
        chk("m_addr", m_addr, cr.addr);
        chk("m_be", {14'd0, m_be}, {14'd0, cr.be});
        chk("m_we", {15'd0, m_we}, {15'd0, cr.we});
        if (cr.we) chk("m_wdata", m_wdata, cr.wdata);
      end
      if (cr.fack) begin
        chk("f_err", {15'd0, f_err}, {15'd0, cr.ferr});
        if (cr.chk_rd) chk("f_rdata", f_rdata, cr.frd);
      end
      if (cr.dack) begin
        chk("d_err", {15'd0, d_err}, {15'd0, cr.derr});
        if (cr.chk_rd) chk("d_rdata", d_rdata, cr.drd);
      end
    end
    if (m_valid === 1'b1 && prev_mv !== 1'b1) begin
      cap_mv_first = cyc;
      cap_mv_run   = 0;
      cap_maddr    = m_addr;
      cap_mbe      = m_be;
      cap_mwe      = m_we;
      cap_mwdata   = m_wdata;
    end
    if (m_valid === 1'b1) cap_mv_run++;
    prev_mv = m_valid;
    if (f_ack === 1'b1 || d_ack === 1'b1) begin
      cap_ack_cyc = cyc;
      cap_ack_d   = d_ack;
      cap_frd     = f_rdata;
      cap_drd     = d_rdata;
      cap_ferr    = f_err;
      cap_derr    = d_err;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rec_t mvrec(input logic sel, input logic [15:0] a, input logic byt,
                                 input logic we, input logic [15:0] w);
    rec_t r = '0;
    r.mv    = 1'b1;
    r.we    = we;
    r.be    = !byt ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    r.addr  = {a[15:1], 1'b0};
    r.wdata = byt ? {w[7:0], w[7:0]} : w;
    r.busy  = 1'b1;
    r.st    = sel ? 2'd2 : 2'd1;
    return r;
  endfunction

  // One arbitration round starting in an IDLE cycle; lat = m_valid cycle on which memory answers.
  task automatic do_txn(input int lat, input logic [15:0] rd);
    logic sel, mis, tmo, byt, we;
    logic [15:0] a, exp_rd;
    int nv;
    rec_t r;
    f_req = pf; f_addr = pf_addr;
    d_req = pd; d_we = pd_we; d_byte = pd_byte; d_addr = pd_addr; d_wdata = pd_wdata;
    m_ready = 1'($urandom % 2);
    m_rdata = 16'($urandom);
    t0 = cyc;
    q.push_back(rec_t'('0));
    if (!pf && !pd) begin
      step();
      return;
    end
    sel      = (pf && pd) ? ~mdl_last : pd;
    mdl_last = sel;
    a   = sel ? pd_addr : pf_addr;
    byt = sel & pd_byte;
    we  = sel & pd_we;
    mis = !byt && a[0];
    tmo = !mis && (lat > TO);
    nv  = mis ? 0 : (tmo ? TO : lat);
    for (int k = 1; k <= nv; k++) q.push_back(mvrec(sel, a, byt, we, pd_wdata));
    if (mis || tmo)  exp_rd = 16'h0000;
    else if (!byt)   exp_rd = rd;
    else if (a[0])   exp_rd = {8'h00, rd[15:8]};
    else             exp_rd = {8'h00, rd[7:0]};
    r = '0;
    r.busy = 1'b1;
    r.st = 2'd3;
    r.chk_rd = !we;
    if (sel) begin
      r.dack = 1'b1; r.derr = mis || tmo; r.drd = exp_rd;
    end else begin
      r.fack = 1'b1; r.ferr = mis || tmo; r.frd = exp_rd;
    end
    q.push_back(r);
    step();
    for (int k = 1; k <= nv; k++) begin
      m_ready = (k == lat);
      m_rdata = (k == lat) ? rd : 16'($urandom);
      step();
    end
    m_ready = 1'($urandom % 2);
    m_rdata = 16'($urandom);
    step();
    if (sel) pd = 1'b0; else pf = 1'b0;
    f_req = pf;
    d_req = pd;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a = 16'($urandom);
    if ($urandom % 6 != 0) a[0] = 1'b0;
    return a;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    f_req = 1'b0; f_addr = 16'h0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
    d_addr = 16'h0; d_wdata = 16'h0; m_ready = 1'b0; m_rdata = 16'h0;
    pf = 1'b0; pd = 1'b0; mdl_last = 1'b0;
    pf_addr = 16'h0; pd_addr = 16'h0; pd_wdata = 16'h0; pd_we = 1'b0; pd_byte = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Both requesters rise together right after reset: data first, then fetch.
    pf = 1'b1; pf_addr = 16'h0200;
    pd = 1'b1; pd_we = 1'b0; pd_byte = 1'b0; pd_addr = 16'h0100;
    do_txn(1, 16'h5555);
    chk("t2_first_is_data", {15'd0, cap_ack_d}, 16'd1);
    chk("t2_d_rdata", cap_drd, 16'h5555);
    do_txn(2, 16'h6666);
    chk("t2_second_is_fetch", {15'd0, cap_ack_d}, 16'd0);
    chk("t2_f_rdata", cap_frd, 16'h6666);

    // Single fetch, memory ready immediately.
    pf = 1'b1; pf_addr = 16'h0010;
    do_txn(1, 16'h1234);
    chk("t1_mvalid_latency", 16'(cap_mv_first - t0), 16'd1);
    chk("t1_ack_latency", 16'(cap_ack_cyc - t0), 16'd2);
    chk("t1_f_rdata", cap_frd, 16'h1234);
    chk("t1_f_err", {15'd0, cap_ferr}, 16'd0);

    // Byte write to the high lane, then byte read of the same lane.
    pd = 1'b1; pd_we = 1'b1; pd_byte = 1'b1; pd_addr = 16'h0021; pd_wdata = 16'h55AB;
    do_txn(1, 16'h0000);
    chk("t3_m_be", {14'd0, cap_mbe}, 16'h0002);
    chk("t3_m_addr", cap_maddr, 16'h0020);
    chk("t3_m_wdata", cap_mwdata, 16'hABAB);
    chk("t3_m_we", {15'd0, cap_mwe}, 16'd1);
    pd = 1'b1; pd_we = 1'b0; pd_byte = 1'b1; pd_addr = 16'h0021;
    do_txn(2, 16'hCD12);
    chk("t3_d_rdata", cap_drd, 16'h00CD);

    // Misaligned word read: no memory cycle, ack one cycle after sampling.
    pd = 1'b1; pd_we = 1'b0; pd_byte = 1'b0; pd_addr = 16'h0003;
    do_txn(1, 16'hFFFF);
    chk("t4_ack_latency", 16'(cap_ack_cyc - t0), 16'd1);
    chk("t4_no_mvalid", {15'd0, cap_mv_first >= t0}, 16'd0);
    chk("t4_d_err", {15'd0, cap_derr}, 16'd1);
    chk("t4_d_rdata", cap_drd, 16'h0000);

    // Memory never answers: TIMEOUT m_valid cycles, then error ack; next access is normal.
    pf = 1'b1; pf_addr = 16'h0080;
    do_txn(9, 16'h1111);
    chk("t5_mvalid_cycles", 16'(cap_mv_run), 16'd4);
    chk("t5_ack_latency", 16'(cap_ack_cyc - t0), 16'd5);
    chk("t5_f_err", {15'd0, cap_ferr}, 16'd1);
    chk("t5_f_rdata", cap_frd, 16'h0000);
    pf = 1'b1; pf_addr = 16'h0082;
    do_txn(3, 16'h2222);
    chk("t5_next_f_rdata", cap_frd, 16'h2222);
    chk("t5_next_f_err", {15'd0, cap_ferr}, 16'd0);

    // Reset in the middle of a data access drops it; arbitration restarts favouring data.
    pd = 1'b1; pd_we = 1'b0; pd_byte = 1'b0; pd_addr = 16'h0040;
    f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0040;
    m_ready = 1'b0;
    q.push_back(rec_t'('0));
    step();
    q.push_back(mvrec(1'b1, 16'h0040, 1'b0, 1'b0, pd_wdata));
    step();
    q.push_back(mvrec(1'b1, 16'h0040, 1'b0, 1'b0, pd_wdata));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mdl_last = 1'b0;
    pf = 1'b1; pf_addr = 16'h0300;
    do_txn(1, 16'h7777);
    chk("t6_data_after_reset", {15'd0, cap_ack_d}, 16'd1);
    chk("t6_ack_latency", 16'(cap_ack_cyc - t0), 16'd2);
    do_txn(1, 16'h8888);

    // Randomized traffic against the model.
    repeat (300) begin
      if (!pf && ($urandom % 3 != 0)) begin
        pf = 1'b1;
        pf_addr = rand_addr();
      end
      if (!pd && ($urandom % 3 != 0)) begin
        pd = 1'b1;
        pd_we = 1'($urandom % 2);
        pd_byte = 1'($urandom % 2);
        pd_addr = rand_addr();
        pd_wdata = 16'($urandom);
      end
      do_txn(1 + int'($urandom % 6), 16'($urandom));
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
